// File: rtl/chunked_seq_adder_pkg.sv
// Shared types and constants for the chunked sequential adder.
package adder_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/chunked_seq_adder_if.sv
// Operand/result handshake bundle for chunked_seq_adder.
interface chunked_seq_adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_A;
  logic [WIDTH-1:0] i_B;
  logic             i_Cin;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_Sum;
  logic             o_Cout;
  logic             o_Ovf;
  logic             o_busy;

  modport slave (
    input  i_valid, i_A, i_B, i_Cin, i_ready,
    output o_ready, o_valid, o_Sum, o_Cout, o_Ovf, o_busy
  );

  modport master (
    output i_valid, i_A, i_B, i_Cin, i_ready,
    input  o_ready, o_valid, o_Sum, o_Cout, o_Ovf, o_busy
  );

endinterface

// File: rtl/chunked_seq_adder_cla.sv
// CarryLookAheadAdder: purely combinational adder with every carry expanded
// as a sum-of-products of generate/propagate terms, no rippling chain.
module CarryLookAheadAdder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_A,
  input  logic [WIDTH-1:0] i_B,
  input  logic             i_Cin,
  output logic [WIDTH-1:0] o_Sum,
  output logic             o_Cout
);

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;

  assign gen  = i_A & i_B;
  assign prop = i_A ^ i_B;

  // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin.
  always_comb begin
    logic acc;
    logic chain;
    acc      = 1'b0;
    chain    = 1'b0;
    carry    = '0;
    carry[0] = i_Cin;
    for (int i = 0; i < WIDTH; i++) begin
      acc   = gen[i];
      chain = prop[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc   = acc | (chain & gen[j]);
        chain = chain & prop[j];
      end
      carry[i+1] = acc | (chain & i_Cin);
    end
  end

  assign o_Sum  = prop ^ carry[WIDTH-1:0];
  assign o_Cout = carry[WIDTH];

endmodule

// File: rtl/chunked_seq_adder.sv
// Wide adder that streams CHUNK bits per cycle through one lookahead slice,
// carrying between slices through a register.
//
//   state | meaning
//   IDLE  | ready for operands; outputs hold the previous result
//   RUN   | one slice per cycle, chunk index 0..NCHUNK-1
//   DONE  | result valid, held until the consumer takes it
module chunked_seq_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  chunked_seq_adder_if.slave   bus
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = idx_width(NCHUNK);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  if ((CHUNK < 2) || ((WIDTH % CHUNK) != 0)) begin : g_param_check
    $error("chunked_seq_adder: WIDTH must be a multiple of CHUNK and CHUNK >= 2");
  end

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;

  logic [CHUNK-1:0]   slice_a;
  logic [CHUNK-1:0]   slice_b;
  logic [CHUNK-1:0]   slice_sum;
  logic               slice_cout;
  int                 slice_lsb;

  assign slice_lsb = int'(idx_q) * CHUNK;
  assign slice_a   = a_q[slice_lsb +: CHUNK];
  assign slice_b   = b_q[slice_lsb +: CHUNK];

  CarryLookAheadAdder #(
    .WIDTH (CHUNK)
  ) u_slice (
    .i_A    (slice_a),
    .i_B    (slice_b),
    .i_Cin  (carry_q),
    .o_Sum  (slice_sum),
    .o_Cout (slice_cout)
  );

  // Next-state: capture in IDLE, one slice per RUN cycle, release on i_ready.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          a_d     = bus.i_A;
          b_d     = bus.i_B;
          carry_d = bus.i_Cin;
          sum_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[slice_lsb +: CHUNK] = slice_sum;
        carry_d                   = slice_cout;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (bus.i_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, operand, sum and inter-slice carry registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  // After the last slice carry_q is the final carry-out and sum_q the result;
  // both stay put through DONE and the following IDLE.
  assign bus.o_ready = (state_q == IDLE);
  assign bus.o_valid = (state_q == DONE);
  assign bus.o_busy  = (state_q != IDLE);
  assign bus.o_Sum   = sum_q;
  assign bus.o_Cout  = carry_q;
  assign bus.o_Ovf   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_q[WIDTH-1] != a_q[WIDTH-1]);

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Directed vectors and handshake corner cases on a CHUNK=8 instance, plus
// random operands applied in lockstep to CHUNK = 2, 4, 8 and 16 instances.
module tb_chunked_seq_adder;
  import adder_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chunked_seq_adder_if #(.WIDTH(32)) bus ();
  chunked_seq_adder_if #(.WIDTH(32)) bus2 ();
  chunked_seq_adder_if #(.WIDTH(32)) bus4 ();
  chunked_seq_adder_if #(.WIDTH(32)) bus16 ();

  chunked_seq_adder #(.WIDTH(32), .CHUNK(8))  dut   (.i_clk(clk), .i_rst(rst), .bus(bus.slave));
  chunked_seq_adder #(.WIDTH(32), .CHUNK(2))  dut2  (.i_clk(clk), .i_rst(rst), .bus(bus2.slave));
  chunked_seq_adder #(.WIDTH(32), .CHUNK(4))  dut4  (.i_clk(clk), .i_rst(rst), .bus(bus4.slave));
  chunked_seq_adder #(.WIDTH(32), .CHUNK(16)) dut16 (.i_clk(clk), .i_rst(rst), .bus(bus16.slave));

  assign bus2.i_valid  = bus.i_valid;  assign bus2.i_ready  = bus.i_ready;
  assign bus2.i_A      = bus.i_A;      assign bus2.i_B      = bus.i_B;
  assign bus2.i_Cin    = bus.i_Cin;
  assign bus4.i_valid  = bus.i_valid;  assign bus4.i_ready  = bus.i_ready;
  assign bus4.i_A      = bus.i_A;      assign bus4.i_B      = bus.i_B;
  assign bus4.i_Cin    = bus.i_Cin;
  assign bus16.i_valid = bus.i_valid;  assign bus16.i_ready = bus.i_ready;
  assign bus16.i_A     = bus.i_A;      assign bus16.i_B     = bus.i_B;
  assign bus16.i_Cin   = bus.i_Cin;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds i_valid until the CHUNK=8 instance accepts; returns true on accept.
  task automatic accept(output bit ok);
    bit was_ready;
    ok = 1'b0;
    bus.i_valid = 1'b1;
    for (int n = 0; n < 60; n++) begin
      was_ready = bus.o_ready;
      tick();
      if (was_ready) begin
        ok = 1'b1;
        break;
      end
    end
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.o_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  logic [32:0] full;
  logic [33:0] exp_r;
  bit          ok;
  int          lat;
  int          acc_cyc[$];
  bit          seen_valid;

  initial begin
    vecs[0] = '{32'h0000_0001, 32'h0000_0002, 1'b0, 32'h0000_0003, 1'b0, 1'b0};
    vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    vecs[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[5] = '{32'h1234_5678, 32'h8765_4321, 1'b0, 32'h9999_9999, 1'b0, 1'b0};
    vecs[6] = '{32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 1'b0, 1'b0};
    vecs[7] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1};

    rst = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_ready = 1'b1;
    bus.i_A = '0;
    bus.i_B = '0;
    bus.i_Cin = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_flags", {bus.o_ready, bus.o_valid, bus.o_busy}, {1'b1, 1'b0, 1'b0});
    chk("reset_data", {bus.o_Sum, bus.o_Cout, bus.o_Ovf}, 64'h0);

    // Directed table; operands are scrambled right after capture.
    for (int v = 0; v < 8; v++) begin
      bus.i_A = vecs[v].a;
      bus.i_B = vecs[v].b;
      bus.i_Cin = vecs[v].cin;
      accept(ok);
      chk($sformatf("v%0d_accept", v), 64'(ok), 64'h1);
      bus.i_A = ~vecs[v].a;
      bus.i_B = ~vecs[v].b;
      bus.i_Cin = ~vecs[v].cin;
      chk($sformatf("v%0d_busy", v), {bus.o_ready, bus.o_busy}, {1'b0, 1'b1});
      wait_valid(lat);
      // o_valid is seen NCHUNK=4 edges after the capture edge.
      chk($sformatf("v%0d_latency", v), 64'(lat), 64'd4);
      chk($sformatf("v%0d_sum", v), bus.o_Sum, vecs[v].sum);
      chk($sformatf("v%0d_cout_ovf", v), {bus.o_Cout, bus.o_Ovf}, {vecs[v].cout, vecs[v].ovf});
      tick();
      chk($sformatf("v%0d_idle_hold", v), {bus.o_valid, bus.o_ready, bus.o_Sum, bus.o_Cout, bus.o_Ovf},
          {1'b0, 1'b1, vecs[v].sum, vecs[v].cout, vecs[v].ovf});
    end

    // Backpressure with stray requests while DONE is held.
    bus.i_ready = 1'b0;
    bus.i_A = 32'h0000_00FF;
    bus.i_B = 32'h0000_0001;
    bus.i_Cin = 1'b0;
    accept(ok);
    chk("bp_accept", 64'(ok), 64'h1);
    wait_valid(lat);
    chk("bp_latency", 64'(lat), 64'd4);
    for (int n = 0; n < 10; n++) begin
      bus.i_valid = n[0];
      bus.i_A = $urandom;
      bus.i_B = $urandom;
      tick();
      chk($sformatf("bp_hold%0d", n), {bus.o_valid, bus.o_ready, bus.o_Sum, bus.o_Cout, bus.o_Ovf},
          {1'b1, 1'b0, 32'h0000_0100, 1'b0, 1'b0});
    end
    // Release with i_valid already high: no accept on the release edge.
    bus.i_A = 32'd5;
    bus.i_B = 32'd6;
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b1;
    tick();
    chk("release_idle", {bus.o_valid, bus.o_ready, bus.o_busy}, {1'b0, 1'b1, 1'b0});
    tick();
    bus.i_valid = 1'b0;
    chk("release_accept_next", {bus.o_ready, bus.o_busy}, {1'b0, 1'b1});
    wait_valid(lat);
    chk("release_sum", {bus.o_Sum, bus.o_Cout, bus.o_Ovf}, {32'd11, 1'b0, 1'b0});
    tick();

    // Reset in the second RUN cycle discards the operation.
    bus.i_A = 32'hFFFF_FFFF;
    bus.i_B = 32'h0;
    bus.i_Cin = 1'b1;
    accept(ok);
    chk("rst_accept", 64'(ok), 64'h1);
    tick();
    rst = 1'b1;
    bus.i_valid = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_valid = 1'b0;
    chk("rst_flags", {bus.o_ready, bus.o_valid, bus.o_busy}, {1'b1, 1'b0, 1'b0});
    chk("rst_data", {bus.o_Sum, bus.o_Cout, bus.o_Ovf}, 64'h0);
    seen_valid = 1'b0;
    for (int n = 0; n < 12; n++) begin
      tick();
      if (bus.o_valid) seen_valid = 1'b1;
    end
    chk("rst_no_result", 64'(seen_valid), 64'h0);

    // Back-to-back: accepts every NCHUNK+2 = 6 cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_A = 32'h0101_0101;
    bus.i_B = 32'h0202_0202;
    bus.i_Cin = 1'b0;
    bus.i_valid = 1'b1;
    bus.i_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (bus.o_ready) acc_cyc.push_back(c);
      tick();
    end
    bus.i_valid = 1'b0;
    chk("b2b_count", 64'(acc_cyc.size()), 64'd4);
    if (acc_cyc.size() >= 3) begin
      chk("b2b_space1", 64'(acc_cyc[1] - acc_cyc[0]), 64'd6);
      chk("b2b_space2", 64'(acc_cyc[2] - acc_cyc[1]), 64'd6);
    end

    // Random operands on all chunk sizes in lockstep.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.i_ready = 1'b0;
    for (int n = 0; n < 1000; n++) begin
      bus.i_A = $urandom;
      bus.i_B = $urandom;
      bus.i_Cin = 1'($urandom_range(1, 0));
      full = {1'b0, bus.i_A} + {1'b0, bus.i_B} + 33'(bus.i_Cin);
      exp_r = {full[32], full[31:0],
               (bus.i_A[31] == bus.i_B[31]) && (full[31] != bus.i_A[31])};
      bus.i_valid = 1'b1;
      tick();
      bus.i_valid = 1'b0;
      lat = 0;
      while (!(bus.o_valid && bus2.o_valid && bus4.o_valid && bus16.o_valid) && lat < 40) begin
        tick();
        lat++;
      end
      if (lat >= 40) begin
        chk("rand_timeout", 64'(n), 64'hFFFF_FFFF);
        break;
      end
      chk($sformatf("rand%0d_c8", n),  {bus.o_Cout,   bus.o_Sum,   bus.o_Ovf},   exp_r);
      chk($sformatf("rand%0d_c2", n),  {bus2.o_Cout,  bus2.o_Sum,  bus2.o_Ovf},  exp_r);
      chk($sformatf("rand%0d_c4", n),  {bus4.o_Cout,  bus4.o_Sum,  bus4.o_Ovf},  exp_r);
      chk($sformatf("rand%0d_c16", n), {bus16.o_Cout, bus16.o_Sum, bus16.o_Ovf}, exp_r);
      bus.i_ready = 1'b1;
      tick();
      bus.i_ready = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
